muldiv_sequencer: RTL and testbench

Multi-cycle sequencer that executes MULT, MULTU, DIV and DIVU by driving the 32-bit ALU one step per cycle. Multiply uses shift-add through ALU ADD (4'b0010). Divide uses restoring division through ALU SUB (4'b0110). The block owns the HI/LO registers and sits beside the ALU in the execute stage. The pipeline stalls on busy.

---
 rtl/muldiv_sequencer_if.sv | 32 +++
 rtl/muldiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Issue/result and ALU-drive signals shared between the execute stage and the
// multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_s;

  modport slave (
    input  start, op, rs, rt, wr_hi, wr_lo, wr_data, alu_s,
    output busy, done, div_zero, hi, lo, alu_a, alu_b, alu_op
  );

  modport master (
    output start, op, rs, rt, wr_hi, wr_lo, wr_data, alu_s,
    input  busy, done, div_zero, hi, lo, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer: one shift-add or restoring-divide step per
// cycle through the shared ALU; owns HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  logic [1:0]       state_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] rs_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] phi_reg;
  logic [WIDTH-1:0] plo_reg;
  logic [4:0]       cnt_reg;
  logic             sign_p_reg;
  logic             sign_r_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             div_zero_reg;

  logic             is_div;
  logic             is_signed;
  logic [WIDTH-1:0] mag_rs;
  logic [WIDTH-1:0] mag_rt;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] alu_a_next;
  logic [WIDTH-1:0] alu_b_next;
  logic [3:0]       alu_op_next;
  logic [WIDTH:0]   sh;
  logic             carry;
  logic             borrow;
  logic             ge;
  logic [WIDTH-1:0] phi_next;
  logic [WIDTH-1:0] plo_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign is_div    = op_reg[1];
  assign is_signed = ~op_reg[0];
  assign alu_s     = bus.alu_s;

  // Magnitudes only matter for the signed ops; unsigned ops pass straight through.
  assign mag_rs = (is_signed && rs_reg[WIDTH-1])  ? -rs_reg  : rs_reg;
  assign mag_rt = (is_signed && opb_reg[WIDTH-1]) ? -opb_reg : opb_reg;

  assign sh       = {phi_reg, plo_reg[WIDTH-1]};
  assign prod     = {phi_reg, plo_reg};
  assign prod_neg = -prod;

  always_comb begin
    alu_a_next  = '0;
    alu_b_next  = '0;
    alu_op_next = ALU_NOP;
    if (state_reg == S_ITER) begin
      if (is_div) begin
        alu_op_next = ALU_SUB;
        alu_a_next  = sh[WIDTH-1:0];
        alu_b_next  = opb_reg;
      end else begin
        alu_op_next = ALU_ADD;
        alu_a_next  = phi_reg;
        alu_b_next  = plo_reg[0] ? opb_reg : '0;
      end
    end
  end

  // Carry/borrow are rebuilt from operand and result sign bits since the ALU
  // exposes only a 32-bit sum.
  always_comb begin
    carry  = (alu_a_next[WIDTH-1] & alu_b_next[WIDTH-1]) |
             ((alu_a_next[WIDTH-1] | alu_b_next[WIDTH-1]) & ~alu_s[WIDTH-1]);
    borrow = (~alu_a_next[WIDTH-1] & alu_b_next[WIDTH-1]) |
             ((~alu_a_next[WIDTH-1] | alu_b_next[WIDTH-1]) & alu_s[WIDTH-1]);
    ge     = sh[WIDTH] | ~borrow;
    if (is_div) begin
      phi_next = ge ? alu_s : sh[WIDTH-1:0];
      plo_next = {plo_reg[WIDTH-2:0], ge};
    end else begin
      phi_next = {carry, alu_s[WIDTH-1:1]};
      plo_next = {alu_s[0], plo_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      op_reg       <= '0;
      rs_reg       <= '0;
      opb_reg      <= '0;
      phi_reg      <= '0;
      plo_reg      <= '0;
      cnt_reg      <= '0;
      sign_p_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            op_reg       <= bus.op;
            rs_reg       <= bus.rs;
            opb_reg      <= bus.rt;
            busy_reg     <= 1'b1;
            div_zero_reg <= 1'b0;
            state_reg    <= S_PREP;
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wr_data;
            if (bus.wr_lo) lo_reg <= bus.wr_data;
          end
        end
        S_PREP: begin
          cnt_reg    <= '0;
          sign_p_reg <= is_signed & (rs_reg[WIDTH-1] ^ opb_reg[WIDTH-1]);
          sign_r_reg <= is_signed & rs_reg[WIDTH-1];
          if (is_div && (opb_reg == '0)) begin
            // Divide by zero: stage the fixed result so FIX just copies it out.
            phi_reg      <= rs_reg;
            plo_reg      <= '1;
            sign_p_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            div_zero_reg <= 1'b1;
            state_reg    <= S_FIX;
          end else if (is_div) begin
            phi_reg   <= '0;
            plo_reg   <= mag_rs;
            opb_reg   <= mag_rt;
            state_reg <= S_ITER;
          end else begin
            phi_reg   <= '0;
            plo_reg   <= mag_rt;
            opb_reg   <= mag_rs;
            state_reg <= S_ITER;
          end
        end
        S_ITER: begin
          phi_reg <= phi_next;
          plo_reg <= plo_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == LAST_ITER) state_reg <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            lo_reg <= sign_p_reg ? -plo_reg : plo_reg;
            hi_reg <= sign_r_reg ? -phi_reg : phi_reg;
          end else begin
            {hi_reg, lo_reg} <= sign_p_reg ? prod_neg : prod;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.alu_a    = alu_a_next;
  assign bus.alu_b    = alu_b_next;
  assign bus.alu_op   = alu_op_next;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues hand-computed
// results, a negedge monitor pops one per done pulse.
module tb_muldiv_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   add_cnt = 0;
  int   sub_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start_cyc;
    int          lat;
    int          adds;
    int          subs;
  } exp_t;

  exp_t sb[$];

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference ALU: only ADD and SUB are exercised by the sequencer.
  always_comb begin
    case (bus.alu_op)
      4'b0010: bus.alu_s = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_s = bus.alu_a - bus.alu_b;
      default: bus.alu_s = 32'h0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        add_cnt = 0;
        sub_cnt = 0;
      end else begin
        if (bus.alu_op == 4'b0010) add_cnt++;
        if (bus.alu_op == 4'b0110) sub_cnt++;
        if (bus.done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_hi"}, bus.hi, e.hi);
            check({e.name, "_lo"}, bus.lo, e.lo);
            check({e.name, "_div_zero"}, bus.div_zero, e.dz);
            check({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
            check({e.name, "_add_cycles"}, add_cnt, e.adds);
            check({e.name, "_sub_cycles"}, sub_cnt, e.subs);
            $display("op %s: hi=%h lo=%h div_zero=%0d latency=%0d", e.name, bus.hi, bus.lo,
                     bus.div_zero, cyc - e.start_cyc);
          end
          add_cnt = 0;
          sub_cnt = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int elat, input int eadds, input int esubs,
                       input bit wr_at_start, input int intrude);
    exp_t e;
    logic [31:0] hi0;
    logic [31:0] lo0;
    bit seen;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    if (wr_at_start) begin
      bus.wr_hi   = 1'b1;
      bus.wr_lo   = 1'b1;
      bus.wr_data = 32'hDEADBEEF;
    end
    e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.start_cyc = cyc + 1; e.lat = elat; e.adds = eadds; e.subs = esubs;
    sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.rs    = 32'h0BAD0BAD;
    bus.rt    = 32'h0BAD0BAD;
    check({name, "_busy"}, bus.busy, 1);
    check({name, "_done_low"}, bus.done, 0);
    check({name, "_hi_hold"}, bus.hi, hi0);
    check({name, "_lo_hold"}, bus.lo, lo0);
    check({name, "_dz_cleared"}, bus.div_zero, 0);
    seen = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clock);
      if (bus.done) begin
        seen = 1'b1;
      end else if (i == intrude) begin
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.rs      = 32'h11111111;
        bus.rt      = 32'h3;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'hA5A5A5A5;
      end else begin
        if (intrude > 0 && i == intrude + 1) check({name, "_hi_busy_write"}, bus.hi, hi0);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
      end
    end
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    check({name, "_done_seen"}, seen, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.rs = 32'h0; bus.rt = 32'h0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = 32'h0;
    repeat (3) @(negedge clock);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_div_zero", bus.div_zero, 0);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_alu_op", bus.alu_op, 4'b0000);
    reset_n = 1'b1;
    @(negedge clock);

    bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    @(negedge clock);
    bus.wr_hi = 1'b0;
    check("mthi_idle", bus.hi, 32'hA5A5A5A5);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h12345678;
    @(negedge clock);
    bus.wr_lo = 1'b0;
    check("mtlo_idle", bus.lo, 32'h12345678);
    check("mtlo_keeps_hi", bus.hi, 32'hA5A5A5A5);
    $display("idle writes: hi=%h lo=%h", bus.hi, bus.lo);

    do_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 32, 0, 1'b1, 0);
    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 32, 0, 1'b0, 0);
    do_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0, 32, 1'b0, 0);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 0, 32, 1'b0, 0);
    do_op("divu_by_0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 2, 0, 0, 1'b0, 0);
    do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 0, 32, 1'b0, 10);
    do_op("mult_m6_m7", 2'b00, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'h0, 32'd42, 1'b0, 34, 32, 0, 1'b0, 0);
    do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 0, 32, 1'b0, 0);

    // Abort a multiply partway through ITER with the async reset.
    bus.start = 1'b1; bus.op = 2'b00; bus.rs = 32'd7; bus.rt = 32'hFFFFFFFD;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (16) @(negedge clock);
    check("mid_iter_alu_op", bus.alu_op, 4'b0010);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_alu_op", bus.alu_op, 4'b0000);
    $display("abort: busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_op("multu_3_5", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 34, 32, 0, 1'b0, 0);

    @(negedge clock);
    check("done_one_cycle", bus.done, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
